// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the ps2keyboard receiver:
// FSM states, keyboard command bytes and frame construction.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_LED    = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_RESEND = 8'hFE;

  localparam int PS2_FRAME_LEN = 11;

  // Frame in transmit order from bit 0: start(0), d0..d7, odd parity, stop(1).
  function automatic logic [PS2_FRAME_LEN-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin plus a registered falling-edge flag.
// Pin-to-fe latency is three clk25 cycles; reusable by the receiver.
module ps2_sync_edge (
  input  logic clk25,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fe
);

  logic s_p0, s_p1, s_p2;

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk25) begin
    if (rst) begin
      s_p0 <= 1'b1;
      s_p1 <= 1'b1;
      s_p2 <= 1'b1;
      fe   <= 1'b0;
    end else begin
      s_p0 <= din;
      s_p1 <= s_p0;
      s_p2 <= s_p1;
      fe   <= s_p2 & ~s_p1;
    end
  end

  assign level = s_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (LED set, reset, resend) with ACK check.
// Define PS2_TX_RETRY_EN to retry a NACKed or timed-out transfer up to twice.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_din_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int INH_CYC = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TO_CYC  = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int CNT_W   = $clog2(TO_CYC + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
  localparam logic [CNT_W-1:0] INH_END  = CNT_W'(INH_CYC);
  // error is registered, so the terminal count sits two below TO_CYC to land
  // the pulse exactly TO_CYC cycles after the last falling edge.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 2);

  ps2_state_t               state;
  logic [CNT_W-1:0]         cnt;
  logic [3:0]               bitcnt;
  logic [PS2_FRAME_LEN-1:0] sr;
  logic                     ack_ok_r;
  logic                     clk_lvl, clk_fe, dat_lvl, dat_fe_unused;
  logic                     accept, shift_en, watch, fin, to_hit, retry_go;

  ps2_sync_edge u_clk_sync (
    .clk25 (clk25),
    .rst   (rst),
    .din   (ps2_clk_in),
    .level (clk_lvl),
    .fe    (clk_fe)
  );

  ps2_sync_edge u_dat_sync (
    .clk25 (clk25),
    .rst   (rst),
    .din   (ps2_din_in),
    .level (dat_lvl),
    .fe    (dat_fe_unused)
  );

  assign accept   = (state == IDLE) && tx_valid;
  assign shift_en = (state == SHIFT) && clk_fe;
  assign watch    = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  assign fin      = (state == WAIT_IDLE) && clk_lvl && dat_lvl;
  assign to_hit   = watch && !clk_fe && (cnt == TO_LAST) && !fin;
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry;
  logic [7:0] tx_byte;

  assign retry_go = (to_hit || (fin && !ack_ok_r)) && (retry != 2'd2);

  always_ff @(posedge clk25) begin
    if (accept) tx_byte <= tx_data;
  end
`else
  assign retry_go = 1'b0;
`endif

  // Frame shift register: bit 0 is the bit currently on the data line.
  always_ff @(posedge clk25) begin
    if (accept) sr <= ps2_frame(tx_data);
`ifdef PS2_TX_RETRY_EN
    else if (retry_go) sr <= ps2_frame(tx_byte);
`endif
    else if (shift_en) sr <= {1'b1, sr[PS2_FRAME_LEN-1:1]};
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state      <= IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      done       <= 1'b0;
      ack_ok     <= 1'b0;
      error      <= 1'b0;
      ack_ok_r   <= 1'b0;
      cnt        <= '0;
      bitcnt     <= '0;
`ifdef PS2_TX_RETRY_EN
      retry      <= '0;
`endif
    end else begin
      done   <= 1'b0;
      ack_ok <= 1'b0;
      error  <= 1'b0;
      if (fin || to_hit) begin
        if (retry_go) begin
          state      <= INHIBIT;
          ps2_clk_oe <= 1'b1;
          ps2_dat_oe <= 1'b0;
          cnt        <= '0;
`ifdef PS2_TX_RETRY_EN
          retry      <= retry + 2'd1;
`endif
        end else begin
          state      <= IDLE;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          done       <= fin;
          ack_ok     <= fin && ack_ok_r;
          error      <= !fin;
        end
      end else begin
        case (state)
          IDLE: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            if (tx_valid) begin
              ps2_clk_oe <= 1'b1;
              cnt        <= '0;
              state      <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retry      <= '0;
`endif
            end
          end
          INHIBIT: begin
            // Start bit goes low one cycle before the clock is released.
            if (cnt == INH_LAST) begin
              ps2_dat_oe <= ~sr[0];
              cnt        <= cnt + CNT_W'(1);
            end else if (cnt == INH_END) begin
              ps2_clk_oe <= 1'b0;
              cnt        <= '0;
              bitcnt     <= '0;
              state      <= SHIFT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SHIFT: begin
            if (clk_fe) begin
              cnt        <= '0;
              ps2_dat_oe <= ~sr[1];
              bitcnt     <= bitcnt + 4'd1;
              if (bitcnt == 4'd9) state <= ACK;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ACK: begin
            if (clk_fe) begin
              cnt      <= '0;
              ack_ok_r <= ~dat_lvl;
              state    <= WAIT_IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          WAIT_IDLE: begin
            if (clk_fe) cnt <= '0;
            else        cnt <= cnt + CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-collector PS/2 keyboard model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_HZ     = 1000000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_US = 1500;
  localparam int INH_CYC    = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TO_CYC     = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int WAIT_MAX   = TO_CYC + 500;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk25 = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_in, ps2_din_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_ok, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int checks = 0, failures = 0, cyc = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, ovl_cnt = 0, busy_drop = 0;
  bit last_ack = 1'b0;
  bit track = 1'b0;

  // Wired-AND of host and device open-collector drivers.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_din_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk25      (clk25),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_din_in (ps2_din_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .error      (error)
  );

  always #20 clk25 = ~clk25;

  always @(posedge clk25) cyc <= cyc + 1;

  always @(negedge clk25) begin
    if (done) begin
      done_cnt++;
      last_ack = ack_ok;
    end
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (ps2_clk_oe && ps2_dat_oe) ovl_cnt++;
    if (done || error) track = 1'b0;
    else if (track && !busy) busy_drop++;
  end

  // Reference frame: start 0, data LSB first, parity making the ones count odd, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!tx_ready && t < WAIT_MAX) begin step(); t++; end
    chk("send_ready", 32'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    track    = 1'b1;
  endtask

  // Keyboard model: measures the inhibit, reads each bit before its rising
  // edge, and on pulse 11 ACKs (data low) unless nack is set.
  task automatic dev_frame(input int npulses, input bit nack, input int half,
                           output logic [10:0] bits, output int inh, output int last_fall);
    int t;
    bits = '1;
    inh = 0;
    last_fall = 0;
    t = 0;
    while (!ps2_clk_oe && t < WAIT_MAX) begin step(); t++; end
    chk("dev_inhibit_seen", 32'(ps2_clk_oe), 1);
    t = 0;
    while (ps2_clk_oe && !ps2_dat_oe && t < WAIT_MAX) begin inh++; step(); t++; end
    t = 0;
    while (ps2_clk_oe && t < WAIT_MAX) begin step(); t++; end
    bits[0] = ps2_din_in;
    repeat (5) step();
    for (int p = 1; p <= npulses; p++) begin
      if (p == 11) begin
        if (!nack) dev_dat_low = 1'b1;
        repeat (5) step();
        dev_clk_low = 1'b1;
        last_fall = cyc;
        repeat (half) step();
        dev_clk_low = 1'b0;
        repeat (10) step();
        dev_dat_low = 1'b0;
        step();
      end else begin
        dev_clk_low = 1'b1;
        last_fall = cyc;
        repeat (half) step();
        bits[p] = ps2_din_in;
        dev_clk_low = 1'b0;
        repeat (half) step();
      end
    end
  endtask

  task automatic do_xfer(input string tag, input logic [7:0] b, input bit nack, input int half);
    logic [10:0] bits, ef;
    int inh, lf, d0, o0, bd0, t, n_att;
    ef = exp_frame(b);
    d0 = done_cnt;
    o0 = ovl_cnt;
    bd0 = busy_drop;
    n_att = nack ? ATTEMPTS : 1;
    send(b);
    for (int a = 0; a < n_att; a++) begin
      dev_frame(11, nack, half, bits, inh, lf);
      chk({tag, "_inhibit_len"}, 32'(inh >= INH_CYC), 1);
      chk({tag, "_frame"}, 32'(bits), 32'(ef));
      chk({tag, "_parity"}, 32'(bits[9]), 32'(ef[9]));
    end
    t = 0;
    while (done_cnt == d0 && t < 200) begin step(); t++; end
    chk({tag, "_done_count"}, 32'(done_cnt - d0), 1);
    chk({tag, "_ack_ok"}, 32'(last_ack), 32'(!nack));
    chk({tag, "_busy_held"}, 32'(busy_drop - bd0), 0);
    chk({tag, "_overlap"}, 32'(ovl_cnt - o0), 32'(n_att));
  endtask

  initial begin
    logic [10:0] fb, ef;
    int fi, fl, d0, e0, t;
    logic [7:0] rb;
    bit rn;

    repeat (4) step();
    chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rst_dat_oe", 32'(ps2_dat_oe), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    rst = 1'b0;
    step();

    do_xfer("led", PS2_CMD_LED, 1'b0, 30);
    do_xfer("zero", 8'h00, 1'b0, 25);
    do_xfer("ones", PS2_CMD_RESET, 1'b0, 35);
    do_xfer("nack", PS2_CMD_RESEND, 1'b1, 30);
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      rn = 1'($urandom_range(0, 1));
      do_xfer("rand", rb, rn, int'($urandom_range(20, 40)));
    end

    // Device stops clocking after d4 is presented.
    d0 = done_cnt;
    e0 = err_cnt;
    ef = exp_frame(8'h5A);
    send(8'h5A);
    for (int a = 0; a < ATTEMPTS; a++) begin
      dev_frame(5, 1'b0, 30, fb, fi, fl);
      chk("to_partial_bits", 32'(fb[5:0]), 32'(ef[5:0]));
    end
    t = 0;
    while (err_cnt == e0 && t < TO_CYC + 200) begin step(); t++; end
    chk("to_error_count", 32'(err_cnt - e0), 1);
    chk("to_latency", 32'(err_cyc - fl), 32'(TO_CYC + 3));
    chk("to_clk_oe", 32'(ps2_clk_oe), 0);
    chk("to_dat_oe", 32'(ps2_dat_oe), 0);
    repeat (100) step();
    chk("to_no_done", 32'(done_cnt - d0), 0);
    chk("to_lines_idle", 32'({ps2_clk_oe, ps2_dat_oe}), 0);

    // Reset in the middle of the data bits.
    d0 = done_cnt;
    send(PS2_CMD_LED);
    dev_frame(5, 1'b0, 30, fb, fi, fl);
    rst = 1'b1;
    step();
    chk("mid_rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("mid_rst_dat_oe", 32'(ps2_dat_oe), 0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    track = 1'b0;
    step();
    chk("mid_rst_no_done", 32'(done_cnt - d0), 0);
    do_xfer("post_rst", PS2_CMD_RESET, 1'b0, 30);

    // A second request while busy must be ignored.
    d0 = done_cnt;
    ef = exp_frame(PS2_CMD_RESEND);
    send(PS2_CMD_RESEND);
    fork
      dev_frame(11, 1'b0, 30, fb, fi, fl);
      begin
        repeat (400) step();
        chk("ign_not_ready", 32'(tx_ready), 0);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
      end
    join
    chk("ign_frame", 32'(fb), 32'(ef));
    t = 0;
    while (done_cnt == d0 && t < 200) begin step(); t++; end
    repeat (600) step();
    chk("ign_done_count", 32'(done_cnt - d0), 1);
    chk("ign_ack_ok", 32'(last_ack), 1);
    chk("ign_idle_after", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
